// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage with a single-entry EX/MEM output register.
// Computes the ALU result, branch decision and branch target, then holds
// them behind a valid/ready handshake toward the MEM stage.
module ex_stage (
   input  logic        clk,
   input  logic        rst,
   // ID/EX handshake and payload
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] pc_i,
   input  logic [31:0] imme_i,
   input  logic [31:0] rdata1_i,
   input  logic [31:0] rdata2_i,
   input  logic [1:0]  ctrl_ALUOp_i,
   input  logic        ctrl_branch_i,
   input  logic        ctrl_mem_to_regs_i,
   input  logic        ctrl_mem_read_i,
   input  logic        ctrl_mem_write_i,
   input  logic        ctrl_alusrc_i,
   input  logic        ctrl_regs_write_i,
   input  logic        ctrl_u_type_i,
   input  logic        ctrl_u_type_auipc_i,
   input  logic [2:0]  funct3_i,
   input  logic        funct7_5_i,
   input  logic [4:0]  regs_rd_i,
   // pipeline kill
   input  logic        flush_i,
   // EX/MEM handshake and payload
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] alu_result_o,
   output logic [31:0] store_data_o,
   output logic [2:0]  funct3_o,
   output logic [4:0]  regs_rd_o,
   output logic        ctrl_mem_to_regs_o,
   output logic        ctrl_mem_read_o,
   output logic        ctrl_mem_write_o,
   output logic        ctrl_regs_write_o,
   output logic        branch_taken_o,
   output logic [31:0] branch_target_o
);

   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  shamt;
   logic [31:0] sra_res;
   logic [31:0] alu_res;
   logic        cmp_true;
   logic        accept;
   logic [31:0] target;

   assign op_a    = rdata1_i;
   assign op_b    = ctrl_alusrc_i ? imme_i : rdata2_i;
   assign shamt   = op_b[4:0];
   assign sra_res = $unsigned($signed(op_a) >>> shamt);
   assign target  = pc_i + imme_i;

   // The output register frees up when empty or being drained this cycle.
   assign in_ready_o = !out_valid_o || out_ready_i;
   assign accept     = in_valid_i && in_ready_o;

   // ALU: U-type override first, then ALUOp/funct3 decode. Subtract is only
   // legal for R-type; I-type funct3=000 is always addi.
   always_comb begin
      alu_res = '0;
      if (ctrl_u_type_i) begin
         alu_res = ctrl_u_type_auipc_i ? target : imme_i;
      end else begin
         case (ctrl_ALUOp_i)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = '0;
            default: begin
               case (funct3_i)
                  3'b000: alu_res = (ctrl_ALUOp_i == 2'b10 && funct7_5_i) ? (op_a - op_b)
                                                                          : (op_a + op_b);
                  3'b001: alu_res = op_a << shamt;
                  3'b010: alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
                  3'b011: alu_res = {31'b0, op_a < op_b};
                  3'b100: alu_res = op_a ^ op_b;
                  3'b101: alu_res = funct7_5_i ? sra_res : (op_a >> shamt);
                  3'b110: alu_res = op_a | op_b;
                  default: alu_res = op_a & op_b;
               endcase
            end
         endcase
      end
   end

   // Branch comparator always works on the two register operands.
   always_comb begin
      cmp_true = 1'b0;
      case (funct3_i)
         3'b000: cmp_true = (rdata1_i == rdata2_i);
         3'b001: cmp_true = (rdata1_i != rdata2_i);
         3'b100: cmp_true = ($signed(rdata1_i) <  $signed(rdata2_i));
         3'b101: cmp_true = ($signed(rdata1_i) >= $signed(rdata2_i));
         3'b110: cmp_true = (rdata1_i <  rdata2_i);
         3'b111: cmp_true = (rdata1_i >= rdata2_i);
         default: cmp_true = 1'b0;
      endcase
   end

   // EX/MEM register: reset beats flush beats accept; payload may still load
   // under flush because only valid/ctrl qualify the entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_o        <= 1'b0;
         branch_taken_o     <= 1'b0;
         ctrl_mem_to_regs_o <= 1'b0;
         ctrl_mem_read_o    <= 1'b0;
         ctrl_mem_write_o   <= 1'b0;
         ctrl_regs_write_o  <= 1'b0;
         alu_result_o       <= '0;
         store_data_o       <= '0;
         branch_target_o    <= '0;
         funct3_o           <= '0;
         regs_rd_o          <= '0;
      end else begin
         if (accept) begin
            alu_result_o    <= alu_res;
            store_data_o    <= rdata2_i;
            branch_target_o <= target;
            funct3_o        <= funct3_i;
            regs_rd_o       <= regs_rd_i;
         end
         if (flush_i) begin
            out_valid_o        <= 1'b0;
            branch_taken_o     <= 1'b0;
            ctrl_mem_to_regs_o <= 1'b0;
            ctrl_mem_read_o    <= 1'b0;
            ctrl_mem_write_o   <= 1'b0;
            ctrl_regs_write_o  <= 1'b0;
         end else if (accept) begin
            out_valid_o        <= 1'b1;
            branch_taken_o     <= ctrl_branch_i && cmp_true;
            ctrl_mem_to_regs_o <= ctrl_mem_to_regs_i;
            ctrl_mem_read_o    <= ctrl_mem_read_i;
            ctrl_mem_write_o   <= ctrl_mem_write_i;
            ctrl_regs_write_o  <= ctrl_regs_write_i;
         end else if (out_valid_o && out_ready_i) begin
            out_valid_o    <= 1'b0;
            branch_taken_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vector table for the ALU/branch datapath plus
// hand-written sequences for stall, drain, flush and reset behaviour.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid_i, in_ready_o;
   logic [31:0] pc_i, imme_i, rdata1_i, rdata2_i;
   logic [1:0]  ctrl_ALUOp_i;
   logic        ctrl_branch_i, ctrl_mem_to_regs_i, ctrl_mem_read_i, ctrl_mem_write_i;
   logic        ctrl_alusrc_i, ctrl_regs_write_i, ctrl_u_type_i, ctrl_u_type_auipc_i;
   logic [2:0]  funct3_i;
   logic        funct7_5_i;
   logic [4:0]  regs_rd_i;
   logic        flush_i;
   logic        out_valid_o, out_ready_i;
   logic [31:0] alu_result_o, store_data_o, branch_target_o;
   logic [2:0]  funct3_o;
   logic [4:0]  regs_rd_o;
   logic        ctrl_mem_to_regs_o, ctrl_mem_read_o, ctrl_mem_write_o, ctrl_regs_write_o;
   logic        branch_taken_o;

   int checks = 0;
   int failures = 0;

   ex_stage dut (
      .clk(clk), .rst(rst),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .pc_i(pc_i), .imme_i(imme_i), .rdata1_i(rdata1_i), .rdata2_i(rdata2_i),
      .ctrl_ALUOp_i(ctrl_ALUOp_i), .ctrl_branch_i(ctrl_branch_i),
      .ctrl_mem_to_regs_i(ctrl_mem_to_regs_i), .ctrl_mem_read_i(ctrl_mem_read_i),
      .ctrl_mem_write_i(ctrl_mem_write_i), .ctrl_alusrc_i(ctrl_alusrc_i),
      .ctrl_regs_write_i(ctrl_regs_write_i), .ctrl_u_type_i(ctrl_u_type_i),
      .ctrl_u_type_auipc_i(ctrl_u_type_auipc_i),
      .funct3_i(funct3_i), .funct7_5_i(funct7_5_i), .regs_rd_i(regs_rd_i),
      .flush_i(flush_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .alu_result_o(alu_result_o), .store_data_o(store_data_o),
      .funct3_o(funct3_o), .regs_rd_o(regs_rd_o),
      .ctrl_mem_to_regs_o(ctrl_mem_to_regs_o), .ctrl_mem_read_o(ctrl_mem_read_o),
      .ctrl_mem_write_o(ctrl_mem_write_o), .ctrl_regs_write_o(ctrl_regs_write_o),
      .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [2:0]  f3;
      logic        f7, src, br, u, au;
      logic [31:0] pc, imm, r1, r2;
      logic [31:0] res;
      logic        tk;
   } vec_t;

   localparam int NV = 28;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic [1:0] op, input logic [2:0] f3,
                               input logic f7, input logic src, input logic br,
                               input logic u, input logic au,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [31:0] res, input logic tk);
      vec_t v;
      v.op = op; v.f3 = f3; v.f7 = f7; v.src = src; v.br = br; v.u = u; v.au = au;
      v.pc = pc; v.imm = imm; v.r1 = r1; v.r2 = r2; v.res = res; v.tk = tk;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      in_valid_i = 0; out_ready_i = 1; flush_i = 0;
      pc_i = 0; imme_i = 0; rdata1_i = 0; rdata2_i = 0;
      ctrl_ALUOp_i = 0; ctrl_branch_i = 0; ctrl_mem_to_regs_i = 0; ctrl_mem_read_i = 0;
      ctrl_mem_write_i = 0; ctrl_alusrc_i = 0; ctrl_regs_write_i = 0;
      ctrl_u_type_i = 0; ctrl_u_type_auipc_i = 0;
      funct3_i = 0; funct7_5_i = 0; regs_rd_i = 0;
   endtask

   // ctl = {mem_to_regs, mem_read, mem_write, regs_write}
   task automatic apply(input vec_t v, input logic [4:0] rd, input logic [3:0] ctl);
      ctrl_ALUOp_i = v.op; funct3_i = v.f3; funct7_5_i = v.f7;
      ctrl_alusrc_i = v.src; ctrl_branch_i = v.br;
      ctrl_u_type_i = v.u; ctrl_u_type_auipc_i = v.au;
      pc_i = v.pc; imme_i = v.imm; rdata1_i = v.r1; rdata2_i = v.r2;
      regs_rd_i = rd;
      {ctrl_mem_to_regs_i, ctrl_mem_read_i, ctrl_mem_write_i, ctrl_regs_write_i} = ctl;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".valid"},  {31'b0, out_valid_o}, 0);
      chk({tag, ".taken"},  {31'b0, branch_taken_o}, 0);
      chk({tag, ".result"}, alu_result_o, 0);
      chk({tag, ".store"},  store_data_o, 0);
      chk({tag, ".target"}, branch_target_o, 0);
      chk({tag, ".f3rd"},   {24'b0, funct3_o, regs_rd_o}, 0);
      chk({tag, ".ctrl"},   {28'b0, ctrl_mem_to_regs_o, ctrl_mem_read_o,
                             ctrl_mem_write_o, ctrl_regs_write_o}, 0);
      chk({tag, ".in_ready"}, {31'b0, in_ready_o}, 1);
   endtask

   initial begin
      vec_t a, b;
      logic [3:0] ctl;
      logic [4:0] rd;

      //           op     f3    f7 sr br u au pc        imm          r1           r2           res          tk
      vecs[0]  = mk(2'b10, 3'b000, 1, 0, 0, 0, 0, 32'h40,   32'h0,       32'd7,       32'd5,       32'd2,       0);
      vecs[1]  = mk(2'b10, 3'b000, 0, 0, 0, 0, 0, 32'h40,   32'h0,       32'd7,       32'd5,       32'd12,      0);
      vecs[2]  = mk(2'b11, 3'b101, 1, 1, 0, 0, 0, 32'h0,    32'h404,     32'h80000000,32'h0,       32'hF8000000,0);
      vecs[3]  = mk(2'b11, 3'b000, 1, 1, 0, 0, 0, 32'h0,    32'hFFFFFFFF,32'd10,      32'h0,       32'd9,       0);
      vecs[4]  = mk(2'b10, 3'b001, 0, 0, 0, 0, 0, 32'h40,   32'h0,       32'd1,       32'd31,      32'h80000000,0);
      vecs[5]  = mk(2'b10, 3'b001, 0, 0, 0, 0, 0, 32'h40,   32'h0,       32'd3,       32'd33,      32'd6,       0);
      vecs[6]  = mk(2'b10, 3'b010, 0, 0, 0, 0, 0, 32'h40,   32'h0,       32'hFFFFFFFF,32'd1,       32'd1,       0);
      vecs[7]  = mk(2'b10, 3'b011, 0, 0, 0, 0, 0, 32'h40,   32'h0,       32'hFFFFFFFF,32'd1,       32'd0,       0);
      vecs[8]  = mk(2'b10, 3'b100, 0, 0, 0, 0, 0, 32'h40,   32'h0,       32'hF0F0,    32'h0FF0,    32'hFF00,    0);
      vecs[9]  = mk(2'b10, 3'b101, 0, 0, 0, 0, 0, 32'h40,   32'h0,       32'h80000000,32'd4,       32'h08000000,0);
      vecs[10] = mk(2'b10, 3'b101, 1, 0, 0, 0, 0, 32'h40,   32'h0,       32'h80000000,32'd4,       32'hF8000000,0);
      vecs[11] = mk(2'b10, 3'b110, 0, 0, 0, 0, 0, 32'h40,   32'h0,       32'hF0,      32'h0F,      32'hFF,      0);
      vecs[12] = mk(2'b10, 3'b111, 0, 0, 0, 0, 0, 32'h40,   32'h0,       32'hF0,      32'h3C,      32'h30,      0);
      vecs[13] = mk(2'b11, 3'b101, 0, 1, 0, 0, 0, 32'h0,    32'h4,       32'h80000000,32'h0,       32'h08000000,0);
      vecs[14] = mk(2'b11, 3'b010, 0, 1, 0, 0, 0, 32'h0,    32'hFFFFFFFF,32'h0,       32'd5,       32'd0,       0);
      vecs[15] = mk(2'b00, 3'b010, 0, 1, 0, 0, 0, 32'h0,    32'h10,      32'h1000,    32'hDEAD,    32'h1010,    0);
      vecs[16] = mk(2'b00, 3'b010, 0, 0, 0, 0, 0, 32'h0,    32'h0,       32'h1000,    32'h10,      32'h1010,    0);
      vecs[17] = mk(2'b01, 3'b100, 0, 1, 1, 0, 0, 32'h100,  32'h20,      32'hFFFFFFFF,32'd1,       32'h0,       1);
      vecs[18] = mk(2'b01, 3'b110, 0, 0, 1, 0, 0, 32'h100,  32'h20,      32'hFFFFFFFF,32'd1,       32'h0,       0);
      vecs[19] = mk(2'b01, 3'b000, 0, 1, 1, 0, 0, 32'h200,  32'h20,      32'd5,       32'd5,       32'h0,       1);
      vecs[20] = mk(2'b01, 3'b001, 0, 0, 1, 0, 0, 32'h200,  32'h8,       32'd5,       32'd5,       32'h0,       0);
      vecs[21] = mk(2'b01, 3'b101, 0, 0, 1, 0, 0, 32'h300,  32'hFFFFFFF0,32'd1,       32'hFFFFFFFF,32'h0,       1);
      vecs[22] = mk(2'b01, 3'b111, 0, 0, 1, 0, 0, 32'h300,  32'h4,       32'd1,       32'hFFFFFFFF,32'h0,       0);
      vecs[23] = mk(2'b01, 3'b010, 0, 0, 1, 0, 0, 32'h300,  32'h4,       32'd5,       32'd5,       32'h0,       0);
      vecs[24] = mk(2'b01, 3'b000, 0, 0, 0, 0, 0, 32'h300,  32'h4,       32'd5,       32'd5,       32'h0,       0);
      vecs[25] = mk(2'b10, 3'b000, 0, 0, 0, 1, 1, 32'h1000, 32'h2000,    32'd7,       32'd5,       32'h3000,    0);
      vecs[26] = mk(2'b10, 3'b000, 0, 0, 0, 1, 0, 32'h1000, 32'h2000,    32'd7,       32'd5,       32'h2000,    0);
      vecs[27] = mk(2'b11, 3'b100, 0, 1, 0, 0, 0, 32'h0,    32'hFFFFFFFF,32'h0000FFFF,32'h0,       32'hFFFF0000,0);

      // reset state
      idle();
      rst = 1;
      @(negedge clk); @(negedge clk);
      chk_zero("reset");
      rst = 0;

      // vector table: back-to-back accept with consume every cycle
      for (int i = 0; i < NV; i++) begin
         rd  = 5'(i);
         ctl = 4'(i);
         apply(vecs[i], rd, ctl);
         in_valid_i = 1; out_ready_i = 1;
         @(negedge clk);
         chk($sformatf("v%0d.valid", i),  {31'b0, out_valid_o}, 1);
         chk($sformatf("v%0d.result", i), alu_result_o, vecs[i].res);
         chk($sformatf("v%0d.taken", i),  {31'b0, branch_taken_o}, {31'b0, vecs[i].tk});
         chk($sformatf("v%0d.target", i), branch_target_o, vecs[i].pc + vecs[i].imm);
         chk($sformatf("v%0d.store", i),  store_data_o, vecs[i].r2);
         chk($sformatf("v%0d.f3rd", i),   {24'b0, funct3_o, regs_rd_o}, {24'b0, vecs[i].f3, rd});
         chk($sformatf("v%0d.ctrl", i),   {28'b0, ctrl_mem_to_regs_o, ctrl_mem_read_o,
                                          ctrl_mem_write_o, ctrl_regs_write_o}, {28'b0, ctl});
      end

      // drain without a new accept
      idle();
      @(negedge clk);
      chk("drain.valid", {31'b0, out_valid_o}, 0);

      // stall: hold A for three cycles while B waits upstream
      a = mk(2'b10, 3'b000, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'd100, 32'd23, 32'd123, 0);
      b = mk(2'b10, 3'b000, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'd1, 32'd1, 32'd2, 0);
      apply(a, 5'd3, 4'b0001);
      in_valid_i = 1; out_ready_i = 0;
      @(negedge clk);
      chk("stallA.valid", {31'b0, out_valid_o}, 1);
      chk("stallA.result", alu_result_o, 123);
      apply(b, 5'd4, 4'b0001);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("stall%0d.in_ready", c), {31'b0, in_ready_o}, 0);
         @(negedge clk);
         chk($sformatf("stall%0d.result", c), alu_result_o, 123);
         chk($sformatf("stall%0d.rd", c), {27'b0, regs_rd_o}, 3);
         chk($sformatf("stall%0d.valid", c), {31'b0, out_valid_o}, 1);
      end
      out_ready_i = 1;
      #1;
      chk("release.in_ready", {31'b0, in_ready_o}, 1);
      @(negedge clk);
      chk("release.result", alu_result_o, 2);
      chk("release.rd", {27'b0, regs_rd_o}, 4);
      chk("release.valid", {31'b0, out_valid_o}, 1);

      // taken branch clears with its valid
      apply(vecs[17], 5'd1, 4'b0000);
      @(negedge clk);
      chk("brq.taken", {31'b0, branch_taken_o}, 1);
      idle();
      @(negedge clk);
      chk("brq.cleared", {31'b0, branch_taken_o}, 0);
      chk("brq.valid", {31'b0, out_valid_o}, 0);

      // flush together with an accept
      apply(vecs[1], 5'd5, 4'b0001);
      in_valid_i = 1;
      @(negedge clk);
      chk("preflush.rw", {31'b0, ctrl_regs_write_o}, 1);
      apply(vecs[17], 5'd6, 4'b1111);
      flush_i = 1;
      @(negedge clk);
      chk("flush.valid", {31'b0, out_valid_o}, 0);
      chk("flush.taken", {31'b0, branch_taken_o}, 0);
      chk("flush.ctrl", {28'b0, ctrl_mem_to_regs_o, ctrl_mem_read_o,
                         ctrl_mem_write_o, ctrl_regs_write_o}, 0);
      idle();

      // reset while holding a valid instruction, with an accept pending
      apply(vecs[17], 5'd7, 4'b1111);
      in_valid_i = 1; out_ready_i = 0;
      @(negedge clk);
      chk("prerst.valid", {31'b0, out_valid_o}, 1);
      out_ready_i = 1; flush_i = 1;
      rst = 1;
      @(negedge clk);
      chk_zero("midrst");
      rst = 0;
      idle();
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter: none; all datapaths fixed at 32 bits, register index 5 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 in_valid_i  in  1  upstream (ID/EX) holds a valid instruction.
REQ-005 in_ready_o  out  1  stage can accept this cycle.
REQ-006 pc_i, imme_i, rdata1_i, rdata2_i  in  32 each  ID/EX payload.
REQ-007 ctrl_ALUOp_i  in  2; ctrl_branch_i, ctrl_mem_to_regs_i, ctrl_mem_read_i, ctrl_mem_write_i, ctrl_alusrc_i, ctrl_regs_write_i, ctrl_u_type_i, ctrl_u_type_auipc_i  in  1 each  ID/EX control.
REQ-008 funct3_i  in  3; funct7_5_i  in  1; regs_rd_i  in  5.
REQ-009 flush_i  in  1  kill the instruction held in the output register.
REQ-010 out_valid_o  out  1; out_ready_i  in  1  EX/MEM handshake with the MEM stage.
REQ-011 alu_result_o  out  32; store_data_o  out  32; funct3_o  out  3; regs_rd_o  out  5.
REQ-012 ctrl_mem_to_regs_o, ctrl_mem_read_o, ctrl_mem_write_o, ctrl_regs_write_o  out  1 each.
REQ-013 branch_taken_o  out  1; branch_target_o  out  32.

Function
REQ-014 Operand A = rdata1_i; operand B = imme_i when ctrl_alusrc_i=1, else rdata2_i.
REQ-015 ALUOp 00: result = A+B (load/store address).
REQ-016 ALUOp 10 (R-type) by funct3: 000 add, or sub when funct7_5=1; 001 sll; 010 slt (signed); 011 sltu; 100 xor; 101 srl, or sra when funct7_5=1; 110 or; 111 and.
REQ-017 ALUOp 11 (I-type): same as ALUOp 10, except funct3=000 is always add; funct7_5 selects sra only for funct3=101.
REQ-018 Shift amount = B[4:0]; all arithmetic is modulo 2^32; slt/sltu yield 32'h0 or 32'h1.
REQ-019 ALUOp 01 (branch): result = 0; compare rdata1_i vs rdata2_i by funct3: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu; 010/011 never taken.
REQ-020 U-type override when ctrl_u_type_i=1: result = pc_i+imme_i if ctrl_u_type_auipc_i=1, else imme_i; ALUOp ignored.
REQ-021 Branch taken = ctrl_branch_i AND compare true; target = pc_i+imme_i, computed for every instruction.
REQ-022 in_ready_o = !out_valid_o || out_ready_i (combinational).
REQ-023 Accept when in_valid_i && in_ready_o: all outputs load the computed values next edge; latency 1 cycle; out_valid_o=1.
REQ-024 out_valid_o=1 && out_ready_i=1 with no accept: out_valid_o clears next edge.
REQ-025 out_valid_o=1 && out_ready_i=0: every output holds stable until consumed.
REQ-026 Simultaneous consume and accept: new instruction loads; out_valid_o stays 1; no bubble.
REQ-027 branch_taken_o is qualified: 1 only while out_valid_o=1; cleared when out_valid_o clears.
REQ-028 flush_i=1: out_valid_o, branch_taken_o, all ctrl_*_o cleared next edge; in_ready_o still follows REQ-022 but accepted input that cycle is discarded; flush wins over accept.
REQ-029 Payload registers (alu_result_o, store_data_o, branch_target_o, funct3_o, regs_rd_o) need not clear on flush; only valid/ctrl are qualifying.
REQ-030 store_data_o = rdata2_i regardless of alusrc.

Reset
REQ-031 rst=1 at an edge: all outputs to 0, including out_valid_o and branch_taken_o; in_ready_o=1 afterwards.
REQ-032 rst mid-transaction discards held instruction; rst has priority over flush and accept.

Verification
REQ-033 R-type, rdata1=7, rdata2=5, funct3=000, funct7_5=1, ALUOp=10 -> next cycle alu_result_o=2, out_valid_o=1.
REQ-034 I-type sra, rdata1=32'h80000000, imme=32'h404, funct3=101, funct7_5=1, alusrc=1 -> alu_result_o=32'hF8000000.
REQ-035 Branch blt, rdata1=32'hFFFFFFFF, rdata2=1, pc=32'h100, imme=32'h20 -> branch_taken_o=1, branch_target_o=32'h120; bltu same operands -> taken 0.
REQ-036 auipc pc=32'h1000, imme=32'h00002000 -> alu_result_o=32'h3000; lui same -> 32'h2000.
REQ-037 out_ready_i=0 three cycles with in_valid_i=1 -> in_ready_o=0, outputs stable; release -> old consumed and new loaded same edge.
REQ-038 flush_i with accept same cycle -> out_valid_o=0, ctrl_regs_write_o=0 next cycle; rst=1 while valid -> all outputs 0 next edge.
